instr_fetch_decode: RTL and testbench

INSTR_FETCH_DECODE -- requirements
Module: instr_fetch_decode

---
 rtl/instr_fetch_decode.sv | 82 ++++++++
 tb/tb_instr_fetch_decode.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_decode.sv
// instr_fetch_decode: loadable instruction memory feeding an R-type fetch/decode stage.
module instr_fetch_decode #(
  parameter int IMEM_DEPTH = 32,
  parameter int PC_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [31:0]     load_data,
  input  logic            start,
  input  logic            stall,
  output logic [4:0]      r1,
  output logic [4:0]      r2,
  output logic [4:0]      r3,
  output logic [5:0]      ctrl,
  output logic            valid,
  output logic            illegal,
  output logic            halted,
  output logic [PC_W-1:0] pc
);
  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
  state_t state;
  logic [31:0] mem [IMEM_DEPTH];
  logic [31:0] word;
  logic legal, done;
  assign word = mem[pc];
  assign legal = (word[31:26] == 6'd0) && (word[5:0] inside {6'h20, 6'h28, 6'h27, 6'h26, 6'h2f, 6'h2e});
  assign halted = (state == HALT);
  always_ff @(posedge clk)
    if (state == IDLE && load_en) mem[load_addr] <= load_data;
  // done marks that the last address has been decoded; HALT follows on the next fetch slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
      ctrl <= '0;
      valid <= 1'b0;
      illegal <= 1'b0;
      done <= 1'b0;
    end else begin
      illegal <= 1'b0;
      case (state)
        IDLE: if (start && !load_en) begin
          state <= FETCH;
          pc <= '0;
          done <= 1'b0;
        end
        FETCH: if (!stall) begin
          if (done || word == 32'd0) begin
            valid <= 1'b0;
            done <= 1'b0;
            state <= HALT;
          end else begin
            valid <= legal;
            illegal <= !legal;
            if (legal) begin
              r1 <= word[25:21];
              r2 <= word[20:16];
              r3 <= word[15:11];
              ctrl <= word[5:0];
            end
            if (&pc) done <= 1'b1;
            else pc <= pc + 1'b1;
          end
        end
        HALT: begin
          valid <= 1'b0;
          if (start) begin
            state <= FETCH;
            pc <= '0;
            done <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_decode.sv
// tb_instr_fetch_decode: scoreboard bench with directed programs for the fetch/decode stage.
module tb_instr_fetch_decode;
  logic clk = 0, rst = 0, load_en = 0, start = 0, stall = 0;
  logic [4:0] load_addr = 0;
  logic [31:0] load_data = 0;
  logic [4:0] r1, r2, r3, pc;
  logic [5:0] ctrl;
  logic valid, illegal, halted;

  instr_fetch_decode #(.IMEM_DEPTH(32), .PC_W(5)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stall(stall), .r1(r1), .r2(r2), .r3(r3), .ctrl(ctrl),
    .valid(valid), .illegal(illegal), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    logic [4:0] r1, r2, r3;
    logic [5:0] ctrl;
    logic [4:0] pc;
  } exp_t;

  exp_t q[$];
  exp_t em;
  int n_chk = 0, n_err = 0;
  logic [5:0] fn [6] = '{6'h20, 6'h28, 6'h27, 6'h26, 6'h2f, 6'h2e};

  function automatic logic [31:0] mk(logic [4:0] a, logic [4:0] b, logic [4:0] c, logic [5:0] f);
    return {6'd0, a, b, c, 5'd0, f};
  endfunction

  function automatic logic [31:0] w32(int i);
    return mk(5'(i), 5'(i + 1), 5'(i + 2), fn[i % 6]);
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(int k, logic [4:0] a, logic [4:0] b, logic [4:0] c, logic [5:0] f, logic [4:0] p);
    exp_t e;
    e.kind = k; e.r1 = a; e.r2 = b; e.r3 = c; e.ctrl = f; e.pc = p;
    q.push_back(e);
  endtask

  // Monitor: a new output is one produced by an unstalled edge, or a rising halted
  logic st_q = 0, h_q = 0;
  int kind_act;
  always @(posedge clk) st_q <= stall;
  always @(negedge clk) begin
    if (!rst && (((valid || illegal) && !st_q) || (halted && !h_q))) begin
      kind_act = halted ? 2 : illegal ? 1 : 0;
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected output: kind %0d pc %0d, none expected", kind_act, pc);
      end else begin
        em = q.pop_front();
        check("kind", 32'(kind_act), 32'(em.kind));
        check("pc", {27'd0, pc}, {27'd0, em.pc});
        check("valid", {31'd0, valid}, {31'd0, em.kind == 0});
        if (em.kind != 2) check("fields", {r1, r2, r3, ctrl}, {em.r1, em.r2, em.r3, em.ctrl});
      end
    end
    h_q = halted;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    check("reset_outputs", {r1, r2, r3, ctrl, valid, illegal, halted, pc}, 32'd0);
    q.delete();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic load(logic [4:0] a, logic [31:0] d);
    load_en = 1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 0;
  endtask

  task automatic do_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic wait_halt(int maxc);
    int n = 0;
    while (!halted && n < maxc) begin
      @(negedge clk);
      n++;
    end
    if (!halted) begin
      n_chk++;
      n_err++;
      $display("FAIL halt_timeout: got halted=0 expected halted=1 within %0d cycles", maxc);
    end
    @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
  endtask

  task automatic push32();
    for (int i = 0; i < 32; i++) push(0, 5'(i), 5'(i + 1), 5'(i + 2), fn[i % 6], i < 31 ? 5'(i + 1) : 5'd31);
    push(2, 0, 0, 0, 0, 5'd31);
  endtask

  initial begin
    int n;
    do_reset();
    // single ADD then halt marker
    load(0, 32'h00463820);
    load(1, 32'h0);
    push(0, 2, 6, 7, 6'h20, 1);
    push(2, 0, 0, 0, 0, 1);
    do_start();
    wait_halt(20);
    check("halted_valid", {31'd0, valid}, 32'd0);
    // SUB, two illegal words holding fields, then halt
    do_reset();
    load(0, 32'h00463828);
    load(1, 32'h0046383f);
    load(2, 32'h20000000);
    load(3, 32'h0);
    push(0, 2, 6, 7, 6'h28, 1);
    push(1, 2, 6, 7, 6'h28, 2);
    push(1, 2, 6, 7, 6'h28, 3);
    push(2, 0, 0, 0, 0, 3);
    do_start();
    wait_halt(20);
    // six functs with a 3-cycle stall after the second output
    do_reset();
    for (int i = 0; i < 6; i++) load(5'(i), mk(5'(i + 1), 5'(i + 8), 5'(i + 16), fn[i]));
    load(6, 32'h0);
    for (int i = 0; i < 6; i++) push(0, 5'(i + 1), 5'(i + 8), 5'(i + 16), fn[i], 5'(i + 1));
    push(2, 0, 0, 0, 0, 6);
    do_start();
    @(negedge clk);
    @(negedge clk);
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_pc", {27'd0, pc}, 32'd2);
      check("stall_out", {valid, illegal, r1, r3, ctrl}, {1'b1, 1'b0, 5'd2, 5'd17, fn[1]});
    end
    stall = 0;
    wait_halt(30);
    // all 32 words legal: no wrap, halt at pc=31
    do_reset();
    for (int i = 0; i < 32; i++) load(5'(i), w32(i));
    push32();
    do_start();
    wait_halt(80);
    check("halt_pc31", {27'd0, pc, halted}, {27'd31, 1'b1});
    // async reset mid-fetch, then rerun from word 0
    do_reset();
    for (int i = 0; i < 3; i++) push(0, 5'(i), 5'(i + 1), 5'(i + 2), fn[i], 5'(i + 1));
    do_start();
    n = 0;
    while (pc != 5'd3 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reached_pc3", {27'd0, pc}, 32'd3);
    #2 rst = 1;
    #1 check("async_reset", {r1, r2, r3, ctrl, valid, illegal, halted, pc}, 32'd0);
    @(negedge clk);
    rst = 0;
    check("queue_before_reset", 32'(q.size()), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_reset", {valid, halted, pc}, 7'd0);
    end
    push32();
    do_start();
    wait_halt(80);
    // start with load_en in IDLE: write only
    do_reset();
    load(1, 32'h0);
    load_en = 1; start = 1; load_addr = 0; load_data = mk(9, 10, 11, 6'h26);
    @(negedge clk);
    load_en = 0; start = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("start_load_idle", {valid, halted, pc}, 7'd0);
    end
    push(0, 9, 10, 11, 6'h26, 1);
    push(2, 0, 0, 0, 0, 1);
    do_start();
    wait_halt(20);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
